// File: rtl/risc_pkg.sv
// Shared definitions for the data-memory responder: datapath widths, FSM
// state encoding and the address range check.
package risc_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int ADDR_IDX_W = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Only the low ADDR_IDX_W bits index storage; any higher bit set is an error.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:ADDR_IDX_W] == '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import risc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [ADDR_IDX_W-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one access, waits
// LATENCY cycles, then presents the response until the requester takes it.
module dmem_responder
  import risc_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept;
  logic              enter_resp;

  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              op_write;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_in_range;

  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the access completes on its accepting edge, so the
  // operation comes straight from the request bus instead of the capture regs.
  always_comb begin
    op_write    = cap_write;
    op_addr     = cap_addr;
    op_wdata    = cap_wdata;
    if (state == IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
    op_in_range = addr_in_range(op_addr);
  end

  // Reset gates the store so a discarded access never reaches storage.
  assign mem_we = clear && enter_resp && op_write && op_in_range;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (op_addr[ADDR_IDX_W-1:0]),
    .wdata (op_wdata),
    .raddr (op_addr[ADDR_IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!clear) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= !op_in_range;
        rdata_q <= (op_in_range && !op_write) ? mem_rdata : '0;
      end else if (state == RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at
// LATENCY=0, sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        clear = 1'b0;

  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_rsp_ready = 1'b0;
  logic [15:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [15:0] a_rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b0;
  logic [15:0] z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [15:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .DEPTH(16)) dut_a (
    .clk(clk), .clear(clear),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.LATENCY(0), .DEPTH(16)) dut_z (
    .clk(clk), .clear(clear),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // Drivers below are entered and left at a falling edge.
  task automatic send_a(input logic w, input logic [15:0] addr, input logic [15:0] data);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = data;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume_a();
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b0;
  endtask

  task automatic access_a(input logic w, input logic [15:0] addr, input logic [15:0] data,
                          output logic [15:0] rd, output logic er, output int n);
    send_a(w, addr, data);
    wait_a(n);
    rd = a_rsp_rdata;
    er = a_rsp_err;
    consume_a();
  endtask

  task automatic test_reset();
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 16'h0 || a_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: rdata=%h err=%b want 0000/0", a_rsp_rdata, a_rsp_err); end
    checks++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_z: ready=%b valid=%b want 1/0", z_req_ready, z_rsp_valid); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic er; int n;
    send_a(1'b1, 16'h0003, 16'h1234);
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_t0: valid=%b ready=%b want 0/0", a_rsp_valid, a_req_ready); end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_t1: valid=%b want 0", a_rsp_valid); end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wr_t2: valid=%b want 1", a_rsp_valid); end
    checks++; if (a_rsp_err !== 1'b0 || a_rsp_rdata !== 16'h0) begin errors++; $display("[TB] FAIL wr_rsp: err=%b rdata=%h want 0/0000", a_rsp_err, a_rsp_rdata); end
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_ready_in_resp: got %b want 0", a_req_ready); end
    consume_a();
    access_a(1'b0, 16'h0003, 16'h0, rd, er, n);
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL rd_latency: got %0d want 2", n); end
    checks++; if (rd !== 16'h1234 || er !== 1'b0) begin errors++; $display("[TB] FAIL rd_data: rdata=%h err=%b want 1234/0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [15:0] rd; logic er; int n;
    access_a(1'b1, 16'h0005, 16'h00AA, rd, er, n);
    send_a(1'b0, 16'h0005, 16'h0);
    wait_a(n);
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 2", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h00AA || a_req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%b rdata=%h ready=%b want 1/00aa/0", i, a_rsp_valid, a_rsp_rdata, a_req_ready);
      end
      @(negedge clk);
    end
    consume_a();
    checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'h0) begin errors++; $display("[TB] FAIL bp_release: ready=%b valid=%b rdata=%h want 1/0/0000", a_req_ready, a_rsp_valid, a_rsp_rdata); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er; int n;
    access_a(1'b1, 16'h0013, 16'hBEEF, rd, er, n);
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL oor_latency: got %0d want 2", n); end
    checks++; if (er !== 1'b1 || rd !== 16'h0) begin errors++; $display("[TB] FAIL oor_store: err=%b rdata=%h want 1/0000", er, rd); end
    access_a(1'b0, 16'h8005, 16'h0, rd, er, n);
    checks++; if (er !== 1'b1 || rd !== 16'h0) begin errors++; $display("[TB] FAIL oor_load: err=%b rdata=%h want 1/0000", er, rd); end
    access_a(1'b0, 16'h0003, 16'h0, rd, er, n);
    checks++; if (rd !== 16'h1234 || er !== 1'b0) begin errors++; $display("[TB] FAIL oor_unchanged: rdata=%h err=%b want 1234/0", rd, er); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rd; logic er; int n; logic seen;
    access_a(1'b1, 16'h0007, 16'h0707, rd, er, n);
    // Reset on the first WAIT edge
    send_a(1'b1, 16'h0007, 16'h5555);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_valid: rsp_valid rose=%b want 0", seen); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_wait_ready: got %b want 1", a_req_ready); end
    // Reset on the very edge that would enter RESP and perform the store
    send_a(1'b1, 16'h0007, 16'h5555);
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_edge: valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready); end
    access_a(1'b0, 16'h0007, 16'h0, rd, er, n);
    checks++; if (rd !== 16'h0707) begin errors++; $display("[TB] FAIL rst_mem_unchanged: rdata=%h want 0707", rd); end
  endtask

  task automatic test_ignored_input();
    logic [15:0] rd; logic er; int n; logic seen;
    send_a(1'b0, 16'h0003, 16'h0);
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 20) begin
      a_req_valid = ~a_req_valid; a_req_write = 1'b1; a_req_addr = 16'h0005; a_req_wdata = 16'hDEAD;
      @(negedge clk);
      n++;
    end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL ign_latency: got %0d want 2", n); end
    for (int i = 0; i < 2; i++) begin
      a_req_valid = 1'b1; a_req_addr = 16'h0009 + 16'(i);
      @(negedge clk);
    end
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL ign_data: valid=%b rdata=%h want 1/1234", a_rsp_valid, a_rsp_rdata); end
    consume_a();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL ign_extra_rsp: extra rsp=%b want 0", seen); end
    access_a(1'b0, 16'h0005, 16'h0, rd, er, n);
    checks++; if (rd !== 16'h00AA) begin errors++; $display("[TB] FAIL ign_mem: rdata=%h want 00aa", rd); end
  endtask

  task automatic test_zero_latency();
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 16'h0002; z_req_wdata = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== 16'h0) begin errors++; $display("[TB] FAIL z_store: valid=%b err=%b rdata=%h want 1/0/0000", z_rsp_valid, z_rsp_err, z_rsp_rdata); end
    z_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_rsp_ready = 1'b0;
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    checks++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 16'h4321) begin errors++; $display("[TB] FAIL z_load: valid=%b rdata=%h want 1/4321", z_rsp_valid, z_rsp_rdata); end
    z_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nrsp;
    nrsp = 0;
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 16'h0002; z_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (z_rsp_valid === 1'b1) nrsp++;
      checks++;
      if (z_rsp_valid !== ((i % 2) == 0) || (z_rsp_valid === 1'b1 && z_rsp_rdata !== 16'h4321)) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: valid=%b rdata=%h want valid=%0d rdata=4321", i, z_rsp_valid, z_rsp_rdata, ((i % 2) == 0));
      end
    end
    z_req_valid = 1'b0; z_rsp_ready = 1'b0;
    checks++; if (nrsp != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d responses want 4", nrsp); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
    test_ignored_input();
    test_zero_latency();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2; wait cycles between request acceptance and response, legal range 0-15.
REQ-002 SHALL have parameter DEPTH, default 16; number of 16-bit data words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  requester presents an access.
REQ-006 SHALL have port req_ready  output  1  responder can accept an access.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  16  word address; only [3:0] indexes storage.
REQ-009 SHALL have port req_wdata  input  16  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-012 SHALL have port rsp_rdata  output  16  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  address out of range (req_addr[15:4] != 0).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE, and never in the same cycle as rsp_valid.
REQ-016 SHALL accept a request on an edge where req_valid and req_ready are both 1, and capture write, addr and wdata at that edge.
REQ-017 On acceptance, SHALL go IDLE->WAIT with the wait counter loaded to LATENCY-1, or IDLE->RESP when LATENCY = 0.
REQ-018 SHALL decrement the counter each cycle in WAIT and go WAIT->RESP on the edge where the counter equals 0.
REQ-019 SHALL first show rsp_valid = 1 in the cycle after the edge LATENCY cycles past the accepting edge.
REQ-020 On entry to RESP, SHALL perform the store for an in-range write, or latch the addressed word into rsp_rdata for an in-range read.
REQ-021 For an out-of-range address, SHALL not modify storage and SHALL respond with rsp_err = 1, rsp_rdata = 0, at the same latency.
REQ-022 In RESP, SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1, then return to IDLE on that edge.
REQ-023 In IDLE and WAIT, SHALL drive rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0.
REQ-024 SHALL ignore req_* inputs while not in IDLE.
REQ-025 SHALL deliver responses strictly in request order, one outstanding access maximum; peak throughput is one access per LATENCY+2 cycles.
REQ-026 A read following a write to the same address SHALL return the written value.

Reset
REQ-027 When clear = 0 at a rising edge, SHALL enter IDLE with counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 1 after release.
REQ-028 Reset in WAIT SHALL discard the pending access, and a pending store SHALL not be performed.
REQ-029 Reset SHALL not alter storage contents; simulation preload from mem.dat is permitted.
REQ-030 Reset SHALL take priority over every simultaneous handshake event.

Structure
REQ-031 Shared package risc_pkg SHALL hold the state enum (IDLE/WAIT/RESP), DATA_W = 16 and ADDR_IDX_W = 4.
REQ-032 Storage SHALL be a sub-module dmem_array: DEPTH x 16, synchronous write, combinational read; FSM and counter stay in dmem_responder.

Verification
REQ-033 Write then read: LATENCY=2; store 0x1234 @ addr 3 accepted at edge T -> rsp_valid high after edge T+2, err=0; then load addr 3 -> rsp_rdata = 0x1234.
REQ-034 Backpressure: load addr 5 (holding 0x00AA) with rsp_ready = 0 for 4 cycles -> rsp_valid and rdata = 0x00AA held for all 4 cycles, req_ready = 0; then rsp_ready = 1 -> IDLE next cycle.
REQ-035 Out of range: store 0xBEEF @ addr 0x0013 -> rsp_err = 1, rdata = 0; subsequent load addr 3 -> unchanged.
REQ-036 Reset mid-op: store 0x5555 @ addr 7, clear = 0 during WAIT -> rsp_valid never rises, addr 7 unchanged, req_ready = 1 after release.
REQ-037 Zero latency: LATENCY = 0, load accepted at edge T -> rsp_valid high in the cycle after T; back-to-back loads -> one access per 2 cycles.
REQ-038 Ignored input: req_valid toggled with new addresses during WAIT/RESP -> no extra responses; data matches the first request only.
